// File: rtl/ctrl_unit.sv
// ctrl_unit: PIC16C5x instruction decode and Q1-Q4 sequencing stage.
// Produces ALU controls, skip/branch flush handling and the Q4 write-back, PC and stack strobes.
`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 4
`endif
`ifndef BIT_SEL_WIDTH
`define BIT_SEL_WIDTH 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module ctrl_unit (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [11:0]                instIn,
    input  logic [`DATA_WIDTH-1:0]     fDataIn,
    input  logic [`DATA_WIDTH-1:0]     aluResultIn,
    output logic [1:0]                 qPhaseOut,
    output logic [`ALU_FUNC_WIDTH-1:0] aluFuncOut,
    output logic [`BIT_SEL_WIDTH-1:0]  bitSelOut,
    output logic [7:0]                 litOut,
    output logic [4:0]                 fAddrOut,
    output logic                       wOpZeroOut,
    output logic [1:0]                 fOpSelOut,
    output logic                       wWrEnOut,
    output logic                       fWrEnOut,
    output logic [2:0]                 statusWrMaskOut,
    output logic                       pcIncOut,
    output logic                       pcLoadOut,
    output logic [8:0]                 pcTargetOut,
    output logic                       pushOut,
    output logic                       popOut
);

    localparam int AW = `ALU_FUNC_WIDTH;
    typedef logic [AW-1:0] aluFunc_t;

    localparam aluFunc_t ALU_DEFAULT = aluFunc_t'(0);
    localparam aluFunc_t ALU_ADDWF   = aluFunc_t'(1);
    localparam aluFunc_t ALU_SUBWF   = aluFunc_t'(2);
    localparam aluFunc_t ALU_ANDWF   = aluFunc_t'(3);
    localparam aluFunc_t ALU_IORWF   = aluFunc_t'(4);
    localparam aluFunc_t ALU_XORWF   = aluFunc_t'(5);
    localparam aluFunc_t ALU_COMF    = aluFunc_t'(6);
    localparam aluFunc_t ALU_DECF    = aluFunc_t'(7);
    localparam aluFunc_t ALU_INCF    = aluFunc_t'(8);
    localparam aluFunc_t ALU_SWAPF   = aluFunc_t'(9);
    localparam aluFunc_t ALU_RLF     = aluFunc_t'(10);
    localparam aluFunc_t ALU_RRF     = aluFunc_t'(11);
    localparam aluFunc_t ALU_BCF     = aluFunc_t'(12);
    localparam aluFunc_t ALU_BSF     = aluFunc_t'(13);
    localparam aluFunc_t ALU_IORLW   = aluFunc_t'(14);
    localparam aluFunc_t ALU_ANDLW   = aluFunc_t'(15);

    localparam logic [1:0] FSEL_REG  = 2'd0;
    localparam logic [1:0] FSEL_LIT  = 2'd1;
    localparam logic [1:0] FSEL_ZERO = 2'd2;

    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

    typedef enum logic [4:0] {
        OP_NOP, OP_MOVWF, OP_CLR, OP_SUBWF, OP_DECF, OP_IORWF, OP_ANDWF,
        OP_XORWF, OP_ADDWF, OP_MOVF, OP_COMF, OP_INCF, OP_DECFSZ, OP_RRF,
        OP_RLF, OP_SWAPF, OP_INCFSZ, OP_BCF, OP_BSF, OP_BTFSC, OP_BTFSS,
        OP_RETLW, OP_CALL, OP_GOTO, OP_MOVLW, OP_IORLW, OP_ANDLW, OP_XORLW
    } op_t;

    phase_t     phase;
    phase_t     phaseNext;
    logic [11:0] ir;
    logic        flush;
    op_t         op;
    aluFunc_t    aluFunc;
    logic        wOpZero;
    logic [1:0]  fOpSel;
    logic        toDest;
    logic        wrW;
    logic        wrF;
    logic [2:0]  mask;
    logic        load;
    logic        push;
    logic        pop;
    logic [8:0]  target;
    logic        skip;
    logic        takeFlush;
    logic        exec;

    // Phase sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= Q1;
        else        phase <= phaseNext;
    end

    always_comb begin
        phaseNext = Q1;
        unique case (phase)
            Q1: phaseNext = Q2;
            Q2: phaseNext = Q3;
            Q3: phaseNext = Q4;
            Q4: phaseNext = Q1;
        endcase
    end

    // A taken skip/branch replaces the just-fetched word with NOP at the same edge,
    // so the flush flag only ever marks the one squashed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir    <= '0;
            flush <= 1'b0;
        end else if (phase == Q4) begin
            flush <= takeFlush;
            ir    <= takeFlush ? '0 : instIn;
        end
    end

    always_comb begin
        op = OP_NOP;
        casez (ir)
            12'b0000_001?_????: op = OP_MOVWF;
            12'b0000_01??_????: op = OP_CLR;
            12'b0000_10??_????: op = OP_SUBWF;
            12'b0000_11??_????: op = OP_DECF;
            12'b0001_00??_????: op = OP_IORWF;
            12'b0001_01??_????: op = OP_ANDWF;
            12'b0001_10??_????: op = OP_XORWF;
            12'b0001_11??_????: op = OP_ADDWF;
            12'b0010_00??_????: op = OP_MOVF;
            12'b0010_01??_????: op = OP_COMF;
            12'b0010_10??_????: op = OP_INCF;
            12'b0010_11??_????: op = OP_DECFSZ;
            12'b0011_00??_????: op = OP_RRF;
            12'b0011_01??_????: op = OP_RLF;
            12'b0011_10??_????: op = OP_SWAPF;
            12'b0011_11??_????: op = OP_INCFSZ;
            12'b0100_????_????: op = OP_BCF;
            12'b0101_????_????: op = OP_BSF;
            12'b0110_????_????: op = OP_BTFSC;
            12'b0111_????_????: op = OP_BTFSS;
            12'b1000_????_????: op = OP_RETLW;
            12'b1001_????_????: op = OP_CALL;
            12'b101?_????_????: op = OP_GOTO;
            12'b1100_????_????: op = OP_MOVLW;
            12'b1101_????_????: op = OP_IORLW;
            12'b1110_????_????: op = OP_ANDLW;
            12'b1111_????_????: op = OP_XORLW;
            default:            op = OP_NOP;
        endcase
    end

    always_comb begin
        aluFunc = ALU_DEFAULT;
        wOpZero = 1'b0;
        fOpSel  = FSEL_REG;
        toDest  = 1'b0;
        wrW     = 1'b0;
        wrF     = 1'b0;
        mask    = 3'b000;
        load    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        target  = '0;
        case (op)
            OP_ADDWF:  begin aluFunc = ALU_ADDWF; mask = 3'b111; toDest = 1'b1; end
            OP_SUBWF:  begin aluFunc = ALU_SUBWF; mask = 3'b111; toDest = 1'b1; end
            OP_ANDWF:  begin aluFunc = ALU_ANDWF; mask = 3'b100; toDest = 1'b1; end
            OP_IORWF:  begin aluFunc = ALU_IORWF; mask = 3'b100; toDest = 1'b1; end
            OP_XORWF:  begin aluFunc = ALU_XORWF; mask = 3'b100; toDest = 1'b1; end
            OP_COMF:   begin aluFunc = ALU_COMF;  mask = 3'b100; toDest = 1'b1; end
            OP_DECF:   begin aluFunc = ALU_DECF;  mask = 3'b100; toDest = 1'b1; end
            OP_INCF:   begin aluFunc = ALU_INCF;  mask = 3'b100; toDest = 1'b1; end
            OP_RLF:    begin aluFunc = ALU_RLF;   mask = 3'b001; toDest = 1'b1; end
            OP_RRF:    begin aluFunc = ALU_RRF;   mask = 3'b001; toDest = 1'b1; end
            OP_SWAPF:  begin aluFunc = ALU_SWAPF; toDest = 1'b1; end
            OP_DECFSZ: begin aluFunc = ALU_DECF;  toDest = 1'b1; end
            OP_INCFSZ: begin aluFunc = ALU_INCF;  toDest = 1'b1; end
            OP_MOVF:   begin aluFunc = ALU_IORWF; wOpZero = 1'b1; mask = 3'b100; toDest = 1'b1; end
            OP_MOVWF:  begin aluFunc = ALU_IORWF; fOpSel = FSEL_ZERO; wrF = 1'b1; end
            OP_CLR:    begin aluFunc = ALU_ANDWF; fOpSel = FSEL_ZERO; mask = 3'b100; toDest = 1'b1; end
            OP_BCF:    begin aluFunc = ALU_BCF;   wrF = 1'b1; end
            OP_BSF:    begin aluFunc = ALU_BSF;   wrF = 1'b1; end
            OP_MOVLW:  begin aluFunc = ALU_IORLW; wOpZero = 1'b1; wrW = 1'b1; end
            OP_IORLW:  begin aluFunc = ALU_IORLW; wrW = 1'b1; mask = 3'b100; end
            OP_ANDLW:  begin aluFunc = ALU_ANDLW; wrW = 1'b1; mask = 3'b100; end
            OP_XORLW:  begin aluFunc = ALU_XORWF; fOpSel = FSEL_LIT; wrW = 1'b1; mask = 3'b100; end
            OP_RETLW:  begin aluFunc = ALU_IORLW; wOpZero = 1'b1; wrW = 1'b1; pop = 1'b1; load = 1'b1; end
            OP_CALL:   begin push = 1'b1; load = 1'b1; target = {1'b0, ir[7:0]}; end
            OP_GOTO:   begin load = 1'b1; target = ir[8:0]; end
            default:   ;
        endcase
        if (toDest) begin
            wrF = ir[5];
            wrW = !ir[5];
        end
    end

    always_comb begin
        skip = 1'b0;
        case (op)
            OP_DECFSZ, OP_INCFSZ: skip = (aluResultIn == '0);
            OP_BTFSC:             skip = !fDataIn[ir[7:5]];
            OP_BTFSS:             skip = fDataIn[ir[7:5]];
            default:              skip = 1'b0;
        endcase
        takeFlush = !flush && (skip || load);
    end

    always_comb begin
        qPhaseOut       = phase;
        aluFuncOut      = aluFunc;
        bitSelOut       = ir[7:5];
        litOut          = ir[7:0];
        fAddrOut        = ir[4:0];
        wOpZeroOut      = wOpZero;
        fOpSelOut       = fOpSel;
        pcTargetOut     = target;
        exec            = (phase == Q4) && !flush;
        wWrEnOut        = exec && wrW;
        fWrEnOut        = exec && wrF;
        statusWrMaskOut = exec ? mask : 3'b000;
        pcLoadOut       = exec && load;
        pushOut         = exec && push;
        popOut          = exec && pop;
        pcIncOut        = (phase == Q4) && !pcLoadOut;
    end

endmodule
